jt900h_memarb: RTL and testbench
================================

# jt900h_memarb

Two-port arbiter and sequencer for the single 16-bit shared work RAM used by the jt900h CPU. Port A (CPU, priority) and port B (DMA/loader/debug master) each issue one read or byte-masked write at a time through a req/ack handshake; the block serialises them onto one RAM interface with configurable read latency. Starvation of port B is bounded. Sits between the CPU bus and the RAM model or BRAM in the top level.

## Interface

- AW, 24, address width of both ports and the RAM bus
- LAT, 1, RAM read latency in cen-qualified cycles from the ram_rd cycle to valid ram_dout (1..3)
- STARVE, 8, consecutive port-A grants allowed while port B is pending

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low (0 = reset)
- cen  in  1  clock enable; all state advances only when cen=1
- a_req  in  1  port A request, held until a_ack
- a_addr  in  AW  port A byte address; bit 0 ignored
- a_we  in  2  port A byte write enables; 00 = read
- a_din  in  16  port A write data
- a_ack  out  1  one-cycle completion pulse
- a_dout  out  16  port A read data, valid with a_ack, held until next port-A read ack
- b_req, b_addr, b_we, b_din, b_ack, b_dout: same as port A for port B
- ram_addr  out  AW  RAM word address, bit 0 always 0
- ram_din  out  16  RAM write data
- ram_we  out  2  RAM byte write strobes
- ram_rd  out  1  RAM read strobe
- ram_dout  in  16  RAM read data

## Operation

- States: IDLE, ACC, WAIT, DONE.
- IDLE: if any req, pick grantee, latch its addr/we/din, go ACC. No req: stay.
- Grant: A wins ties, unless starve counter == STARVE, then B wins.
- Starve counter: +1 per A grant while b_req=1; cleared on B grant or any cen cycle with b_req=0; saturates at STARVE.
- ACC: drive ram_addr = {addr[AW-1:1],0}; write: ram_we = latched we for exactly this cycle, go DONE; read: ram_rd=1 this cycle only, go WAIT (LAT-1 further cycles counted).
- WAIT: counts LAT cycles after ACC; in the cycle LAT after ACC, capture ram_dout into the grantee's dout register, go DONE. With LAT=1, WAIT lasts one cycle.
- DONE: grantee's ack=1 for one cycle; no arbitration; next state IDLE.
- ram_addr/ram_din hold last value outside ACC; ram_we=0, ram_rd=0 outside ACC.
- Requester keeps req and fields stable until ack. req still high in the cycle after ack = new request (back-to-back allowed).
- Dropping req before ack is illegal; behaviour undefined but must not hang the FSM (access completes, ack issued).
- Non-grantee dout and ack never change.

## Timing

- Reset (rst=0 at a cen=1 edge): state IDLE, a_ack=b_ack=0, ram_we=0, ram_rd=0, ram_addr=0, ram_din=0, a_dout=b_dout=0, starve counter 0. Reset mid-access aborts: no ack, strobes low next cycle.
- cen=0 freezes all state and outputs; strobes and ack stretch across cen=0 cycles.
- Write: req sampled in IDLE cycle 0 -> ram_we cycle 1 -> ack cycle 2. Throughput one write per 3 cycles.
- Read: req cycle 0 -> ram_rd cycle 1 -> capture cycle 1+LAT -> ack cycle 2+LAT; dout valid from ack cycle.
- Arbitration decided only in IDLE; a request arriving during ACC/WAIT/DONE waits.

## Test plan

- Reset: hold rst=0 with a_req=1 for 4 cycles -> ram_we=0, ram_rd=0, acks 0, ram_addr=0; release -> first ram strobe 1 cycle later.
- Single write: a_req, a_addr=0x000123, a_we=01, a_din=0xBEEF -> cycle 1 ram_addr=0x000122, ram_we=01, ram_din=0xBEEF; a_ack cycle 2 only.
- Read LAT=2: b_req, b_addr=0x40, RAM word 0x40=0x1234 -> ram_rd cycle 1, b_ack cycle 4, b_dout=0x1234; a_dout unchanged.
- Tie: a_req and b_req both raised cycle 0 -> A served first, B's ram strobe at cycle 4, b_ack cycle 5 (writes).
- Starvation STARVE=8: a_req held continuously with back-to-back writes, b_req held -> exactly 8 A grants, then one B grant, then A resumes; counter resets.
- cen toggling every cycle during a LAT=1 read -> same ordering, each step on cen=1 edges, a_ack held exactly one cen cycle, data correct.

Source files
------------

// File: rtl/jt900h_memarb.sv
// jt900h_memarb
// Two-port arbiter/sequencer for the single 16-bit shared work RAM.
// Port A (CPU) has priority; port B (DMA/loader/debug) is guaranteed service
// after at most STARVE consecutive port-A grants while it is waiting.
//
// Handshake: a requester raises req with addr/we/din stable and keeps them
// stable until it sees its one-cycle ack (cen-qualified). req still high in
// the cycle after ack is a new request. we = 00 is a read; dout is valid from
// the ack cycle and held until the next read ack on that port.
//
// Ports
//   clk, rst (sync, active-low), cen (clock enable for all state)
//   a_req/a_addr/a_we/a_din -> a_ack/a_dout   port A (priority)
//   b_req/b_addr/b_we/b_din -> b_ack/b_dout   port B
//   ram_addr/ram_din/ram_we/ram_rd -> ram_dout RAM side, LAT read latency
//   fsm_state                                  debug view of the sequencer
module jt900h_memarb #(
   parameter int AW     = 24,
   parameter int LAT    = 1,
   parameter int STARVE = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          a_req,
   input  logic [AW-1:0] a_addr,
   input  logic [1:0]    a_we,
   input  logic [15:0]   a_din,
   output logic          a_ack,
   output logic [15:0]   a_dout,
   input  logic          b_req,
   input  logic [AW-1:0] b_addr,
   input  logic [1:0]    b_we,
   input  logic [15:0]   b_din,
   output logic          b_ack,
   output logic [15:0]   b_dout,
   output logic [AW-1:0] ram_addr,
   output logic [15:0]   ram_din,
   output logic [1:0]    ram_we,
   output logic          ram_rd,
   input  logic [15:0]   ram_dout,
   output logic [1:0]    fsm_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);
   localparam logic [1:0]    WAIT_LAST  = 2'(LAT - 1);

   state_t        state;
   state_t        state_nx;
   logic          gnt_b;       // grantee of the current access: 1 = port B
   logic [1:0]    we_q;        // latched byte enables of the grantee
   logic [1:0]    wait_cnt;    // WAIT cycles already spent
   logic [SW-1:0] starve_cnt;  // A grants given while B was waiting
   logic          pick_b;
   logic          unused_addr_lsb;

   // Byte addresses arrive with bit 0 set for odd bytes; the RAM is word wide.
   assign unused_addr_lsb = a_addr[0] ^ b_addr[0];

   // B wins when A is idle, or when A has had its full share of grants.
   assign pick_b = b_req & (~a_req | (starve_cnt == STARVE_MAX));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (a_req | b_req) state_nx = ACC;
         ACC:  state_nx = (we_q != 2'b00) ? DONE : WAIT;
         WAIT: if (wait_cnt == WAIT_LAST) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (cen) begin
         if (!rst) begin
            state      <= IDLE;
            gnt_b      <= 1'b0;
            we_q       <= 2'b00;
            wait_cnt   <= 2'd0;
            starve_cnt <= '0;
            ram_addr   <= '0;
            ram_din    <= 16'h0000;
            a_dout     <= 16'h0000;
            b_dout     <= 16'h0000;
         end else begin
            state <= state_nx;
            case (state)
               IDLE: begin
                  // Address/data are registered here so they appear in ACC
                  // and then hold until the next access.
                  if (a_req | b_req) begin
                     gnt_b <= pick_b;
                     if (pick_b) begin
                        we_q     <= b_we;
                        ram_addr <= {b_addr[AW-1:1], 1'b0};
                        ram_din  <= b_din;
                     end else begin
                        we_q     <= a_we;
                        ram_addr <= {a_addr[AW-1:1], 1'b0};
                        ram_din  <= a_din;
                     end
                  end
               end
               ACC: wait_cnt <= 2'd0;
               WAIT: begin
                  wait_cnt <= wait_cnt + 2'd1;
                  // Last WAIT cycle is LAT cycles after the read strobe.
                  if (wait_cnt == WAIT_LAST) begin
                     if (gnt_b) b_dout <= ram_dout;
                     else       a_dout <= ram_dout;
                  end
               end
               default: ;
            endcase

            // Starvation bookkeeping only matters while B is waiting.
            if (!b_req) begin
               starve_cnt <= '0;
            end else if (state == IDLE) begin
               if (pick_b) starve_cnt <= '0;
               else if (a_req && starve_cnt != STARVE_MAX)
                  starve_cnt <= starve_cnt + SW'(1);
            end
         end
      end
   end

   // Strobes and acks decode straight from the state so a reset or cen=0
   // affects them in lock-step with the sequencer.
   assign ram_we    = (state == ACC) ? we_q : 2'b00;
   assign ram_rd    = (state == ACC) && (we_q == 2'b00);
   assign a_ack     = (state == DONE) && !gnt_b;
   assign b_ack     = (state == DONE) &&  gnt_b;
   assign fsm_state = state;

endmodule

// File: tb/tb_jt900h_memarb.sv
module tb_jt900h_memarb;

   localparam int AW = 24;
   localparam int LAT = 2;
   localparam int STARVE = 8;
   localparam int AKW = 34;   // {cyc16, port, rd, data16}
   localparam int RMW = 59;   // {cyc16, rd, we2, addr24, din16}

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cen = 1'b1;
   logic          a_req = 1'b0, b_req = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [1:0]    a_we = 2'b00, b_we = 2'b00;
   logic [15:0]   a_din = 16'h0, b_din = 16'h0;
   logic          a_ack, b_ack, ram_rd;
   logic [15:0]   a_dout, b_dout, ram_din, ram_dout;
   logic [AW-1:0] ram_addr;
   logic [1:0]    ram_we, fsm_state;

   bit toggle = 1'b0;
   int cyc = 0;
   int n_checks = 0;
   int n_err = 0;

   logic [AKW-1:0] ack_q[$];
   logic [RMW-1:0] ram_q[$];
   logic [AKW-1:0] ae;
   logic [RMW-1:0] re;
   logic [15:0]    sh_a, sh_b;

   jt900h_memarb #(.AW(AW), .LAT(LAT), .STARVE(STARVE)) dut (
      .clk(clk), .rst(rst), .cen(cen),
      .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_din(a_din),
      .a_ack(a_ack), .a_dout(a_dout),
      .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_din(b_din),
      .b_ack(b_ack), .b_dout(b_dout),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
      .ram_rd(ram_rd), .ram_dout(ram_dout), .fsm_state(fsm_state)
   );

   // clock / clock enable / cen-cycle counter
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      cen = toggle ? ~cen : 1'b1;
   end

   always @(posedge clk) if (cen) cyc <= cyc + 1;

   // RAM model: byte-masked writes, two cen-stage read pipeline (LAT=2)
   logic [15:0] mem [0:1023];
   logic [15:0] rd_s1, rd_s2;
   logic [9:0]  ram_idx;
   assign ram_idx  = ram_addr[10:1];
   assign ram_dout = rd_s2;

   always @(posedge clk) begin
      if (cen) begin
         if (!rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
            mem[10'h020] <= 16'h1234;
            rd_s1 <= 16'h0;
            rd_s2 <= 16'h0;
         end else begin
            if (ram_we[0]) mem[ram_idx][7:0]  <= ram_din[7:0];
            if (ram_we[1]) mem[ram_idx][15:8] <= ram_din[15:8];
            if (ram_rd) rd_s1 <= mem[ram_idx];
            rd_s2 <= rd_s1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_evt(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: got event expected none (cyc %0d)", name, cyc);
   endtask

   // monitor / scoreboard: one pop per cen-qualified strobe or ack
   always @(negedge clk) begin
      if (!rst) begin
         sh_a = 16'h0;
         sh_b = 16'h0;
      end else if (cen) begin
         if (ram_we != 2'b00 || ram_rd) begin
            if (ram_q.size() == 0) fail_evt("ram_unexpected");
            else begin
               re = ram_q.pop_front();
               chk("ram_cyc", 32'(cyc), 32'(re[58:43]));
               chk("ram_rd", 32'(ram_rd), 32'(re[42]));
               chk("ram_we", 32'(ram_we), 32'(re[41:40]));
               chk("ram_addr", 32'(ram_addr), 32'(re[39:16]));
               if (!re[42]) chk("ram_din", 32'(ram_din), 32'(re[15:0]));
            end
         end
         if (a_ack && b_ack) fail_evt("both_acks");
         if (a_ack || b_ack) begin
            if (ack_q.size() == 0) fail_evt("ack_unexpected");
            else begin
               ae = ack_q.pop_front();
               chk("ack_cyc", 32'(cyc), 32'(ae[33:18]));
               chk("ack_port", 32'(b_ack), 32'(ae[17]));
               if (ae[17]) begin
                  if (ae[16]) begin
                     chk("b_dout", 32'(b_dout), 32'(ae[15:0]));
                     sh_b = ae[15:0];
                  end else chk("b_dout_hold", 32'(b_dout), 32'(sh_b));
                  chk("a_dout_hold", 32'(a_dout), 32'(sh_a));
               end else begin
                  if (ae[16]) begin
                     chk("a_dout", 32'(a_dout), 32'(ae[15:0]));
                     sh_a = ae[15:0];
                  end else chk("a_dout_hold", 32'(a_dout), 32'(sh_a));
                  chk("b_dout_hold", 32'(b_dout), 32'(sh_b));
               end
            end
         end
      end
   end

   // driver tasks
   task automatic step();
      int c = cyc;
      while (cyc == c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input bit port, input logic [AW-1:0] addr,
                        input logic [1:0] we, input logic [15:0] din);
      if (!port) begin
         a_req = 1'b1; a_addr = addr; a_we = we; a_din = din;
      end else begin
         b_req = 1'b1; b_addr = addr; b_we = we; b_din = din;
      end
   endtask

   task automatic drop(input bit port);
      if (!port) a_req = 1'b0;
      else       b_req = 1'b0;
   endtask

   task automatic exp_ram(input int c, input bit rd, input logic [1:0] we,
                          input logic [AW-1:0] addr, input logic [15:0] din);
      ram_q.push_back({16'(c), rd, we, addr, din});
   endtask

   task automatic exp_ack(input int c, input bit port, input bit rd, input logic [15:0] data);
      ack_q.push_back({16'(c), port, rd, data});
   endtask

   // waits for the port's ack, moves to the following cycle, optionally
   // keeps req high there (back-to-back request)
   task automatic wait_ack(input bit port, input bit keep);
      int n = 0;
      while (!(port ? b_ack : a_ack) && n < 60) begin
         step();
         n++;
      end
      chk(port ? "b_ack_timeout" : "a_ack_timeout", 32'(n < 60), 32'd1);
      step();
      if (!keep) drop(port);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      // reset held with a pending write
      issue(1'b0, 24'h000010, 2'b11, 16'hA5A5);
      repeat (4) step();
      @(negedge clk);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_ram_rd", 32'(ram_rd), 32'd0);
      chk("rst_a_ack", 32'(a_ack), 32'd0);
      chk("rst_b_ack", 32'(b_ack), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_din", 32'(ram_din), 32'd0);
      chk("rst_a_dout", 32'(a_dout), 32'd0);
      chk("rst_b_dout", 32'(b_dout), 32'd0);
      chk("rst_state", 32'(fsm_state), 32'd0);
      t = cyc;
      rst = 1'b1;
      exp_ram(t + 1, 1'b0, 2'b11, 24'h000010, 16'hA5A5);
      exp_ack(t + 2, 1'b0, 1'b0, 16'h0);
      wait_ack(1'b0, 1'b0);

      // single low-byte write at an odd address
      step(); t = cyc;
      issue(1'b0, 24'h000123, 2'b01, 16'hBEEF);
      exp_ram(t + 1, 1'b0, 2'b01, 24'h000122, 16'hBEEF);
      exp_ack(t + 2, 1'b0, 1'b0, 16'h0);
      wait_ack(1'b0, 1'b0);

      // port B read, LAT=2
      step(); t = cyc;
      issue(1'b1, 24'h000040, 2'b00, 16'h0);
      exp_ram(t + 1, 1'b1, 2'b00, 24'h000040, 16'h0);
      exp_ack(t + 4, 1'b1, 1'b1, 16'h1234);
      wait_ack(1'b1, 1'b0);

      // port A reads back the byte write
      step(); t = cyc;
      issue(1'b0, 24'h000123, 2'b00, 16'h0);
      exp_ram(t + 1, 1'b1, 2'b00, 24'h000122, 16'h0);
      exp_ack(t + 4, 1'b0, 1'b1, 16'h00EF);
      wait_ack(1'b0, 1'b0);

      // tie on writes: A first, B strobe at 4, ack at 5
      step(); t = cyc;
      issue(1'b0, 24'h000200, 2'b11, 16'h1111);
      issue(1'b1, 24'h000202, 2'b10, 16'h2222);
      exp_ram(t + 1, 1'b0, 2'b11, 24'h000200, 16'h1111);
      exp_ram(t + 4, 1'b0, 2'b10, 24'h000202, 16'h2222);
      exp_ack(t + 2, 1'b0, 1'b0, 16'h0);
      exp_ack(t + 5, 1'b1, 1'b0, 16'h0);
      wait_ack(1'b0, 1'b0);
      wait_ack(1'b1, 1'b0);

      // tie on reads: cross read-back
      step(); t = cyc;
      issue(1'b0, 24'h000202, 2'b00, 16'h0);
      issue(1'b1, 24'h000200, 2'b00, 16'h0);
      exp_ram(t + 1, 1'b1, 2'b00, 24'h000202, 16'h0);
      exp_ram(t + 6, 1'b1, 2'b00, 24'h000200, 16'h0);
      exp_ack(t + 4, 1'b0, 1'b1, 16'h2200);
      exp_ack(t + 9, 1'b1, 1'b1, 16'h1111);
      wait_ack(1'b0, 1'b0);
      wait_ack(1'b1, 1'b0);

      // starvation: 8 A grants, then B, then A again
      step(); t = cyc;
      issue(1'b0, 24'h000300, 2'b11, 16'h3333);
      issue(1'b1, 24'h000302, 2'b11, 16'h4444);
      for (int i = 0; i < 8; i++) exp_ram(t + 3 * i + 1, 1'b0, 2'b11, 24'h000300, 16'h3333);
      exp_ram(t + 25, 1'b0, 2'b11, 24'h000302, 16'h4444);
      exp_ram(t + 28, 1'b0, 2'b11, 24'h000300, 16'h3333);
      exp_ram(t + 31, 1'b0, 2'b11, 24'h000300, 16'h3333);
      for (int i = 0; i < 8; i++) exp_ack(t + 3 * i + 2, 1'b0, 1'b0, 16'h0);
      exp_ack(t + 26, 1'b1, 1'b0, 16'h0);
      exp_ack(t + 29, 1'b0, 1'b0, 16'h0);
      exp_ack(t + 32, 1'b0, 1'b0, 16'h0);
      fork
         wait_ack(1'b1, 1'b0);
         begin
            for (int i = 0; i < 10; i++) wait_ack(1'b0, 1'b1);
            drop(1'b0);
         end
      join

      // cen toggling every cycle
      step(); toggle = 1'b1; step(); step();
      t = cyc;
      issue(1'b0, 24'h000040, 2'b10, 16'hAB00);
      exp_ram(t + 1, 1'b0, 2'b10, 24'h000040, 16'hAB00);
      exp_ack(t + 2, 1'b0, 1'b0, 16'h0);
      wait_ack(1'b0, 1'b0);
      step(); t = cyc;
      issue(1'b0, 24'h000041, 2'b00, 16'h0);
      exp_ram(t + 1, 1'b1, 2'b00, 24'h000040, 16'h0);
      exp_ack(t + 4, 1'b0, 1'b1, 16'hAB34);
      wait_ack(1'b0, 1'b0);
      step(); t = cyc;
      issue(1'b1, 24'h000302, 2'b00, 16'h0);
      exp_ram(t + 1, 1'b1, 2'b00, 24'h000302, 16'h0);
      exp_ack(t + 4, 1'b1, 1'b1, 16'h4444);
      wait_ack(1'b1, 1'b0);
      step(); toggle = 1'b0; step(); step();

      // reset during an access: no ack, strobe gone
      t = cyc;
      issue(1'b1, 24'h000040, 2'b00, 16'h0);
      exp_ram(t + 1, 1'b1, 2'b00, 24'h000040, 16'h0);
      step();
      @(negedge clk); #1;
      rst = 1'b0;
      drop(1'b1);
      step();
      chk("abort_ram_rd", 32'(ram_rd), 32'd0);
      chk("abort_state", 32'(fsm_state), 32'd0);
      chk("abort_b_ack", 32'(b_ack), 32'd0);
      repeat (3) step();
      rst = 1'b1;
      repeat (6) step();
      @(negedge clk);
      chk("abort_b_dout", 32'(b_dout), 32'd0);
      chk("abort_ram_addr", 32'(ram_addr), 32'd0);

      chk("ram_q_left", 32'(ram_q.size()), 32'd0);
      chk("ack_q_left", 32'(ack_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
